// File: rtl/dram_image_reader.sv
// ---------------------------------------------------------------------------
// dram_image_reader
//   AXI4 read master behind the image sender's DRAM read interface. Each
//   dram_read_en pulse requests (dram_read_len + 1) beats starting at the
//   beat-aligned byte address dram_read_addr. The request is issued as one
//   INCR burst, or as two bursts when it would cross a BOUNDARY_BYTES
//   boundary. Every accepted AXI beat is returned one cycle later on
//   dram_read_data / dram_read_data_valid.
//
// Ports
//   clk_pixel, dram_reader_reset_n : clock, asynchronous active-low reset
//   dram_read_addr/len/en          : request (address, beats-1, strobe)
//   dram_read_data/_data_valid     : returned beat and its one-cycle strobe
//   dram_read_busy                 : request in progress
//   dram_read_error                : sticky, bad rresp or rlast mismatch
//   dram_read_overrun              : sticky, request strobe while busy
//   m_axi_ar* / m_axi_r*           : AXI4 read address and read data channels
// ---------------------------------------------------------------------------
module dram_image_reader #(
  parameter int unsigned DRAM_ADDR_WIDTH = 39,
  parameter int unsigned DRAM_DATA_WIDTH = 128,
  parameter int unsigned BOUNDARY_BYTES  = 4096
) (
  input  logic                       clk_pixel,
  input  logic                       dram_reader_reset_n,
  input  logic [DRAM_ADDR_WIDTH-1:0] dram_read_addr,
  input  logic [7:0]                 dram_read_len,
  input  logic                       dram_read_en,
  output logic [DRAM_DATA_WIDTH-1:0] dram_read_data,
  output logic                       dram_read_data_valid,
  output logic                       dram_read_busy,
  output logic                       dram_read_error,
  output logic                       dram_read_overrun,
  output logic [DRAM_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]                 m_axi_arlen,
  output logic [2:0]                 m_axi_arsize,
  output logic [1:0]                 m_axi_arburst,
  output logic                       m_axi_arvalid,
  input  logic                       m_axi_arready,
  input  logic [DRAM_DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]                 m_axi_rresp,
  input  logic                       m_axi_rlast,
  input  logic                       m_axi_rvalid,
  output logic                       m_axi_rready
);

  localparam int unsigned BEAT_BYTES = DRAM_DATA_WIDTH / 8;
  localparam int unsigned BEAT_BITS  = $clog2(BEAT_BYTES);
  localparam int unsigned OFF_BITS   = $clog2(BOUNDARY_BYTES);
  localparam logic [8:0]  BEATS_PER_BOUNDARY = 9'(BOUNDARY_BYTES / BEAT_BYTES);
  localparam logic [DRAM_ADDR_WIDTH-1:0] BEAT_MASK  = DRAM_ADDR_WIDTH'(BEAT_BYTES - 1);
  localparam logic [DRAM_ADDR_WIDTH-1:0] BOUND_MASK = DRAM_ADDR_WIDTH'(BOUNDARY_BYTES - 1);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;

  state_e                       state_q, state_d;
  logic [DRAM_ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [7:0]                   arlen_q, arlen_d;
  logic [8:0]                   rem_q, rem_d;
  logic [7:0]                   beat_q, beat_d;
  logic [DRAM_DATA_WIDTH-1:0]   data_q, data_d;
  logic                         valid_q, valid_d;
  logic                         busy_q, busy_d;
  logic                         err_q, err_d;
  logic                         ovr_q, ovr_d;

  logic [DRAM_ADDR_WIDTH-1:0]   req_addr;
  logic [8:0]                   req_total;
  logic [8:0]                   req_room;
  logic [8:0]                   req_first;
  logic                         accept;
  logic                         ar_fire;
  logic                         r_fire;
  logic                         last_beat;

  // Request decode: beats left before the boundary, computed in 9 bits so an
  // aligned address yields the full 256.
  assign req_addr  = dram_read_addr & ~BEAT_MASK;
  assign req_total = {1'b0, dram_read_len} + 9'd1;
  assign req_room  = BEATS_PER_BOUNDARY - 9'(req_addr[OFF_BITS-1:BEAT_BITS]);
  assign req_first = (req_total < req_room) ? req_total : req_room;

  // busy_q covers the whole request including the final strobe cycle, so it
  // alone decides whether a new strobe is taken or counted as an overrun.
  assign accept    = dram_read_en && !busy_q;
  assign ar_fire   = (state_q == ADDR) && m_axi_arready;
  assign r_fire    = (state_q == DATA) && m_axi_rvalid;
  assign last_beat = (beat_q == arlen_q);

  // State register
  always_ff @(posedge clk_pixel or negedge dram_reader_reset_n) begin
    if (!dram_reader_reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a burst ends on the beat counter, never on rlast.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = ADDR;
      ADDR: if (m_axi_arready) state_d = DATA;
      DATA: if (r_fire && last_beat) state_d = (rem_q != 9'd0) ? ADDR : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the state register
  always_comb begin
    m_axi_arvalid = (state_q == ADDR);
    m_axi_rready  = (state_q == DATA);
  end

  // Datapath next-state
  always_comb begin
    addr_d  = addr_q;
    arlen_d = arlen_q;
    rem_d   = rem_q;
    beat_d  = beat_q;
    data_d  = data_q;
    valid_d = 1'b0;
    err_d   = err_q;
    ovr_d   = ovr_q;

    if (dram_read_en && busy_q) ovr_d = 1'b1;

    if (accept) begin
      addr_d  = req_addr;
      arlen_d = 8'(req_first - 9'd1);
      rem_d   = req_total - req_first;
    end

    if (ar_fire) beat_d = 8'd0;

    if (r_fire) begin
      data_d  = m_axi_rdata;
      valid_d = 1'b1;
      beat_d  = beat_q + 8'd1;
      if (m_axi_rresp != 2'b00)     err_d = 1'b1;
      if (m_axi_rlast != last_beat) err_d = 1'b1;
      if (last_beat && (rem_q != 9'd0)) begin
        // Second burst starts on the boundary the first one stopped at.
        addr_d  = (addr_q | BOUND_MASK) + DRAM_ADDR_WIDTH'(1);
        arlen_d = 8'(rem_q - 9'd1);
        rem_d   = 9'd0;
      end
    end

    busy_d = (state_d != IDLE) || valid_d;
  end

  always_ff @(posedge clk_pixel or negedge dram_reader_reset_n) begin
    if (!dram_reader_reset_n) begin
      addr_q  <= '0;
      arlen_q <= '0;
      rem_q   <= '0;
      beat_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      arlen_q <= arlen_d;
      rem_q   <= rem_d;
      beat_q  <= beat_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      ovr_q   <= ovr_d;
    end
  end

  assign dram_read_data       = data_q;
  assign dram_read_data_valid = valid_q;
  assign dram_read_busy       = busy_q;
  assign dram_read_error      = err_q;
  assign dram_read_overrun    = ovr_q;
  assign m_axi_araddr         = addr_q;
  assign m_axi_arlen          = arlen_q;
  assign m_axi_arsize         = 3'b100;
  assign m_axi_arburst        = 2'b01;

endmodule
